// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of the single-port data memory: grants one of two
// requesters per cycle, forms byte lanes for stores and extends load data.
module dmem_arbiter #(
  parameter int ADD_WIDTH = 18
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_uns,
  input  logic [31:0] m0_add,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_uns,
  input  logic [31:0] m1_add,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic [31:0] mem_add,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef struct packed {
    logic       valid;
    logic       port;
    logic       we;
    logic [1:0] size;
    logic [1:0] lsb;
    logic       uns;
    logic       err;
  } tag_t;

  tag_t        tag;
  logic        last;

  logic        any_gnt;
  logic        g_we;
  logic [1:0]  g_size;
  logic        g_uns;
  logic [31:0] g_add;
  logic [31:0] g_wdata;
  logic        g_align;
  logic        g_range;
  logic        g_legal;

  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] resp_data;
  logic        resp;

  // On a tie the port that did not win last time gets the slot.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m0_req && (!m1_req || last)) m0_gnt = 1'b1;
      else if (m1_req)                 m1_gnt = 1'b1;
    end
  end

  assign any_gnt = m0_gnt | m1_gnt;
  assign g_we    = m1_gnt ? m1_we    : m0_we;
  assign g_size  = m1_gnt ? m1_size  : m0_size;
  assign g_uns   = m1_gnt ? m1_uns   : m0_uns;
  assign g_add   = m1_gnt ? m1_add   : m0_add;
  assign g_wdata = m1_gnt ? m1_wdata : m0_wdata;

  always_comb begin
    case (g_size)
      2'b00:   g_align = 1'b1;
      2'b01:   g_align = ~g_add[0];
      2'b10:   g_align = (g_add[1:0] == 2'b00);
      default: g_align = 1'b0;
    endcase
  end

  assign g_range = ((g_add >> ADD_WIDTH) == 32'd0);
  assign g_legal = g_align & g_range;

  always_comb begin
    mem_add   = 32'd0;
    mem_wen   = 4'b0000;
    mem_wdata = 32'd0;
    if (any_gnt) begin
      mem_add = {g_add[31:2], 2'b00};
      if (g_we && g_legal) begin
        case (g_size)
          2'b00: begin
            mem_wen   = 4'b0001 << g_add[1:0];
            mem_wdata = {4{g_wdata[7:0]}};
          end
          2'b01: begin
            mem_wen   = g_add[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{g_wdata[15:0]}};
          end
          2'b10: begin
            mem_wen   = 4'b1111;
            mem_wdata = g_wdata;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      tag  <= '0;
      last <= 1'b1;
    end else begin
      tag.valid <= any_gnt;
      tag.port  <= m1_gnt;
      tag.we    <= g_we;
      tag.size  <= g_size;
      tag.lsb   <= g_add[1:0];
      tag.uns   <= g_uns;
      tag.err   <= ~g_legal;
      if (any_gnt) last <= m1_gnt;
    end
  end

  // The memory word arrives one cycle after its address, aligned with the tag.
  always_comb begin
    shifted = mem_rdata >> {tag.lsb, 3'b000};
    case (tag.size)
      2'b00:   ext = {{24{~tag.uns & shifted[7]}},  shifted[7:0]};
      2'b01:   ext = {{16{~tag.uns & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
    resp_data = (tag.we || tag.err) ? 32'd0 : ext;
  end

  assign resp      = tag.valid & ~reset;
  assign m0_rvalid = resp & ~tag.port;
  assign m1_rvalid = resp &  tag.port;
  assign m0_err    = m0_rvalid & tag.err;
  assign m1_err    = m1_rvalid & tag.err;
  assign m0_rdata  = m0_rvalid ? resp_data : 32'd0;
  assign m1_rdata  = m1_rvalid ? resp_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-level memory model plus pending-response model,
// compared against the DUT every cycle; directed cases then randomized traffic.
module tb_dmem_arbiter;
  localparam int ADD_WIDTH = 18;
  localparam int NWORDS    = 1 << (ADD_WIDTH - 2);

  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] add;
    logic [31:0] wdata;
  } rq_t;

  logic        clk = 1'b0;
  logic        reset;
  rq_t         rq0, rq1;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_add, mem_wdata, mem_rdata;
  logic [3:0]  mem_wen;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADD_WIDTH(ADD_WIDTH)) dut (
    .clk(clk), .reset(reset),
    .m0_req(rq0.req), .m0_we(rq0.we), .m0_size(rq0.size), .m0_uns(rq0.uns),
    .m0_add(rq0.add), .m0_wdata(rq0.wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(rq1.req), .m1_we(rq1.we), .m1_size(rq1.size), .m1_uns(rq1.uns),
    .m1_add(rq1.add), .m1_wdata(rq1.wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_add(mem_add), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_byte(int a);
    return 8'((a * 13) ^ (a >> 7) ^ 90);
  endfunction

  function automatic logic [31:0] init_word(int w);
    return {init_byte(4*w+3), init_byte(4*w+2), init_byte(4*w+1), init_byte(4*w)};
  endfunction

  // Memory behind the DUT: lane writes at the edge, registered read word.
  logic [31:0] ram [0:NWORDS-1];
  bit          ram_ready;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int w = 0; w < NWORDS; w++) ram[w] <= init_word(w);
      ram_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (mem_wen[k]) ram[mem_add[ADD_WIDTH-1:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
    mem_rdata <= ram[mem_add[ADD_WIDTH-1:2]];
  end

  // Reference model state.
  logic [7:0]  mm [int];
  int          last_m;
  bit          p_valid;
  int          p_port;
  bit          p_err;
  logic [31:0] p_data;
  bit          e_g0, e_g1;

  int total, bad;

  logic [1:0]  s_gnt;
  logic        s_rv0, s_rv1, s_er0, s_er1;
  logic [31:0] s_rd0, s_rd1, s_add, s_wdata;
  logic [3:0]  s_wen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_byte(int a);
    if (mm.exists(a)) return mm[a];
    return init_byte(a);
  endfunction

  // Observe one cycle at the falling edge, then advance the model across the next rising edge.
  task automatic step();
    rq_t         g;
    int          port, nb, lo, a;
    bit          legal, x_rv0, x_rv1;
    logic [3:0]  x_wen;
    logic [31:0] x_wdata, x_data;
    @(negedge clk);
    s_gnt = {m1_gnt, m0_gnt};
    s_rv0 = m0_rvalid; s_rv1 = m1_rvalid; s_er0 = m0_err; s_er1 = m1_err;
    s_rd0 = m0_rdata;  s_rd1 = m1_rdata;
    s_add = mem_add;   s_wen = mem_wen;   s_wdata = mem_wdata;

    e_g0 = 1'b0; e_g1 = 1'b0;
    if (!reset) begin
      e_g0 = rq0.req && (!rq1.req || last_m == 1);
      e_g1 = rq1.req && !e_g0;
    end
    check("gnt", 32'(s_gnt), 32'({e_g1, e_g0}));

    x_rv0 = !reset && p_valid && p_port == 0;
    x_rv1 = !reset && p_valid && p_port == 1;
    check("rvalid0", 32'(s_rv0), 32'(x_rv0));
    check("rvalid1", 32'(s_rv1), 32'(x_rv1));
    if (x_rv0 || reset) begin
      check("err0",   32'(s_er0), 32'(x_rv0 && p_err));
      check("rdata0", s_rd0, x_rv0 ? p_data : 32'd0);
    end
    if (x_rv1 || reset) begin
      check("err1",   32'(s_er1), 32'(x_rv1 && p_err));
      check("rdata1", s_rd1, x_rv1 ? p_data : 32'd0);
    end

    if (e_g0 || e_g1) begin
      g     = e_g0 ? rq0 : rq1;
      port  = e_g1 ? 1 : 0;
      nb    = 1 << g.size;
      lo    = int'(g.add[1:0]);
      a     = int'(g.add);
      legal = g.size != 2'b11 && (g.add % nb) == 0 && g.add < 32'(1 << ADD_WIDTH);
      x_wen = 4'b0000; x_wdata = 32'd0; x_data = 32'd0;
      if (legal && g.we) begin
        for (int b = 0; b < nb; b++) x_wen[lo+b] = 1'b1;
        for (int k = 0; k < 4; k++) x_wdata[8*k +: 8] = g.wdata[8*(k % nb) +: 8];
        for (int b = 0; b < nb; b++) mm[a+b] = g.wdata[8*b +: 8];
        check("mem_wdata", s_wdata, x_wdata);
      end else if (legal) begin
        for (int b = 0; b < nb; b++) x_data |= 32'(rd_byte(a+b)) << (8*b);
        if (!g.uns && nb < 4 && x_data[8*nb-1]) x_data |= ~((32'd1 << (8*nb)) - 32'd1);
      end
      if (legal) check("mem_add", s_add, g.add & ~32'h3);
      check("mem_wen", 32'(s_wen), 32'(x_wen));
      p_valid = 1'b1; p_port = port; p_err = !legal; p_data = x_data;
      last_m  = port;
    end else begin
      check("idle_add",   s_add, 32'd0);
      check("idle_wen",   32'(s_wen), 32'd0);
      check("idle_wdata", s_wdata, 32'd0);
      p_valid = 1'b0;
    end
    if (reset) begin
      p_valid = 1'b0;
      last_m  = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one request on a port, hold it until granted, then drop it.
  task automatic do_req(input int port, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] add, input logic [31:0] wdata);
    rq_t r;
    bit  got;
    r.req = 1'b1; r.we = we; r.size = size; r.uns = uns; r.add = add; r.wdata = wdata;
    if (port == 0) rq0 = r; else rq1 = r;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = (port == 0) ? e_g0 : e_g1;
    end
    check("grant_timeout", 32'(got), 32'd1);
    if (port == 0) rq0.req = 1'b0; else rq1.req = 1'b0;
  endtask

  function automatic rq_t rand_req();
    rq_t r;
    int  k;
    k       = $urandom_range(0, 19);
    r.req   = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.uns   = 1'($urandom_range(0, 1));
    r.size  = (k == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    r.wdata = $urandom();
    r.add   = 32'h100 + 32'($urandom_range(0, 63));
    if (k == 1) r.add = 32'h0004_0000 + 32'($urandom_range(0, 63));
    if (k == 2) r.add = 32'h1000_0100 + 32'($urandom_range(0, 63));
    if (k >= 3 && k < 16 && r.size != 2'b11) r.add = r.add & ~(32'(1 << r.size) - 32'd1);
    return r;
  endfunction

  typedef struct { bit we; logic [1:0] size; logic [31:0] add; } bad_t;
  bad_t bad_tab [4] = '{'{1'b0, 2'b10, 32'h102}, '{1'b1, 2'b01, 32'h101},
                        '{1'b0, 2'b11, 32'h100}, '{1'b1, 2'b10, 32'h0004_0000}};

  initial begin
    int n0, n1;
    total = 0; bad = 0;
    last_m = 1; p_valid = 1'b0;
    reset = 1'b1; rq0 = '0; rq1 = '0;
    repeat (3) step();
    check("reset_rv0", 32'(s_rv0), 32'd0);
    reset = 1'b0;

    // Tie straight out of reset: m0 first.
    rq0 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0};
    rq1 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0};
    step();
    check("tie_first", 32'(s_gnt), 32'd1);
    rq0.req = 1'b0;
    step();
    check("tie_second", 32'(s_gnt), 32'd2);
    check("tie_rd0", s_rd0, init_word(4));
    rq1.req = 1'b0;
    step();
    check("tie_rd1", s_rd1, init_word(8));

    // Byte store then signed / unsigned byte loads.
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_0080);
    check("sb_wen", 32'(s_wen), 32'b1000);
    check("sb_wdata", s_wdata, 32'h8080_8080);
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    step();
    check("lb_signed", s_rd0, 32'hFFFF_FF80);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    step();
    check("lb_unsigned", s_rd0, 32'h0000_0080);

    // Half store merged into a word.
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h104, 32'h1122_3344);
    do_req(1, 1'b1, 2'b01, 1'b0, 32'h106, 32'h0000_BEEF);
    check("sh_wen", 32'(s_wen), 32'b1100);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    step();
    check("lw_merged", s_rd0, 32'hBEEF_3344);
    do_req(1, 1'b0, 2'b01, 1'b0, 32'h106, 32'h0);
    step();
    check("lh_signed", s_rd1, 32'hFFFF_BEEF);

    // Rejected requests never touch memory.
    foreach (bad_tab[i]) begin
      do_req(0, bad_tab[i].we, bad_tab[i].size, 1'b0, bad_tab[i].add, 32'hDEAD_BEEF);
      check("err_wen", 32'(s_wen), 32'd0);
      step();
      check("err_flag", 32'(s_er0), 32'd1);
      check("err_rdata", s_rd0, 32'd0);
    end
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    step();
    check("err_nochange", s_rd0, {8'h80, init_byte(32'h102), init_byte(32'h101), init_byte(32'h100)});

    // Fairness: hand the last grant to m1 first, then both hold req.
    do_req(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    step();
    rq0 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0};
    rq1 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0};
    n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("fair_gnt", 32'(s_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      n0 += int'(s_rv0); n1 += int'(s_rv1);
    end
    rq0.req = 1'b0; rq1.req = 1'b0;
    step();
    n0 += int'(s_rv0); n1 += int'(s_rv1);
    check("fair_rv0", 32'(n0), 32'd3);
    check("fair_rv1", 32'(n1), 32'd3);

    // Reset lands on the response cycle of an m0 load.
    rq0 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0};
    step();
    check("mid_gnt", 32'(s_gnt), 32'd1);
    rq0.req = 1'b0;
    reset = 1'b1;
    step();
    check("mid_drop", 32'(s_rv0), 32'd0);
    step();
    reset = 1'b0;
    rq0 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0};
    rq1 = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0};
    step();
    check("mid_tie", 32'(s_gnt), 32'd1);
    rq0.req = 1'b0;
    step();
    rq1.req = 1'b0;
    step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (!rq0.req && $urandom_range(0, 9) < 6) rq0 = rand_req();
      if (!rq1.req && $urandom_range(0, 9) < 6) rq1 = rand_req();
      reset = ($urandom_range(0, 199) == 0);
      step();
      if (e_g0) rq0.req = 1'b0;
      if (e_g1) rq1.req = 1'b0;
    end
    reset = 1'b0; rq0.req = 1'b0; rq1.req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between two requesters: port 0 is the core load/store unit and port 1 is the program loader/debug DMA. The block arbitrates round-robin and issues at most one access per cycle. It also does the byte-lane work: it turns byte, half and word stores into lane enables with replicated write data, and it extracts and sign- or zero-extends load data from the memory's registered read word. Misaligned, out-of-range and bad-size requests are rejected with an error response and never reach the memory.

## Interface
- ADD_WIDTH, 18, byte-address width of the data memory; addresses with any bit set in [31:ADD_WIDTH] are out of range.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- mN_req  in  1  request valid, N = 0,1; held until granted
- mN_we  in  1  1 = store, 0 = load
- mN_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- mN_uns  in  1  load zero-extend (1) or sign-extend (0)
- mN_add  in  32  byte address
- mN_wdata  in  32  store data, right-justified
- mN_gnt  out  1  combinational grant in the request cycle
- mN_rvalid  out  1  one-cycle response pulse, loads and stores
- mN_rdata  out  32  extended load data; 0 for stores and errors
- mN_err  out  1  qualifies mN_rvalid; access rejected
- mem_add  out  32  to the memory address input
- mem_wen  out  4  lane enables to the memory
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word, registered, valid the cycle after its address

## Operation
- **Arbitration:** combinational.
  - One requesting port wins outright.
  - When both request, the winner is the port not in `last`.
  - `last` updates to the winner on every grant.
  - `last` resets to 1, so m0 wins the first tie.
  - Exactly one gnt at most per cycle.
- **Legality check** on the granted request; err when any of:
  - size = 11;
  - half with add[0] = 1;
  - word with add[1:0] != 0;
  - add[31:ADD_WIDTH] != 0.
- **Illegal grant:** still consumes the slot and gets a response. mem_wen = 0. mem_add is still driven and is harmless.
- **Memory drive for a legal grant:**
  - mem_add = {add[31:2], 2'b00}.
  - Store lane enables:
    - byte: mem_wen = 1 << add[1:0], mem_wdata = {4{wdata[7:0]}};
    - half: mem_wen = add[1] ? 1100 : 0011, mem_wdata = {2{wdata[15:0]}};
    - word: mem_wen = 1111, mem_wdata = wdata.
  - Loads: mem_wen = 0.
- **Idle cycles:** mem_add = 0, mem_wen = 0, mem_wdata = 0.
- **Response tag:** registered at the grant edge. It holds valid, port, we, size, add[1:0], uns and err.
- **Response cycle:**
  - rvalid/err are driven only on the tagged port.
  - Load data: shifted = mem_rdata >> (8·add[1:0]). The result is byte [7:0] or half [15:0], extended per uns; a word passes through.
- **Store completion:** the memory merges lanes in the grant cycle, so a store is complete at the grant edge.
- **Back-to-back accesses:** a new grant may occur every cycle. A load following a store to the same word returns the stored data.

## Timing
- Grant: same cycle as req (combinational).
- Response latency: exactly 1 cycle after the grant cycle for every request, legal or not.
- Throughput: 1 access/cycle. A port requesting continuously alone is granted every cycle; two continuous requesters alternate 0,1,0,1.
- Request hold: the requester must keep req and all request fields stable until gnt. Fields may change in the cycle after gnt.
- Reset:
  - While reset = 1: gnt, rvalid, err, rdata, mem_wen and mem_wdata are 0, and mem_add = 0.
  - The tag's valid bit clears and `last` = 1.
- Reset mid-operation: a response due in the cycle after reset asserts is dropped (no rvalid). A store granted in the same cycle that reset asserts is not issued.
- Simultaneous response and new grant in one cycle is normal: the response goes to the tagged port while the new grant goes to either port.

## Test plan
- **Reset then tie:** deassert reset; m0 and m1 both request a word load at 0x10 and 0x20 in the same cycle.
  - m0_gnt first, m0 rvalid next cycle with mem[4].
  - m1 is granted in the following cycle and returns mem[8].
- **Byte store / signed load:**
  - m0 stores byte 0x80 at 0x103; mem_wen = 1000, mem_wdata = 0x80808080.
  - A load byte at 0x103 with uns=0 returns 0xFFFFFF80; with uns=1 it returns 0x00000080.
- **Half store:** word 0x104 = 0x11223344; m1 stores half 0xBEEF at 0x106 (mem_wen = 1100).
  - A word load at 0x104 returns 0xBEEF3344.
  - A half load at 0x106 with uns=0 returns 0xFFFFBEEF.
- **Errors:** all of these give err=1 one cycle later, mem_wen = 0 and memory unchanged:
  - word load at 0x102;
  - half store at 0x101;
  - size=11;
  - address 0x0004_0000 (out of range at ADD_WIDTH=18).
- **Fairness:** both ports hold req for 6 cycles; grants alternate m0,m1,m0,m1,m0,m1, and each port sees 3 rvalid pulses.
- **Reset mid-flight:** m0 load granted at cycle t; reset=1 at t+1. No m0_rvalid appears, and after release m0 wins the first tie.
